rate_gen: RTL and testbench

- Parametrised, runtime-programmable data-rate clock generator; successor to the fixed divide-by-22 square-wave divider.
- Produces a 50%-duty rate square wave plus single-cycle tick strobes for downstream backscatter modulation/symbol logic.
- Half-period divisor is reloadable at runtime and applied glitch-free at half-period boundaries.
- Has an enable with a return-to-zero idle state and an optional fractional divisor.

---
 rtl/rate_gen_pkg.sv | 13 +
 rtl/rate_frac_acc.sv | 33 +++
 rtl/rate_gen.sv | 141 ++++++++++++++
 tb/tb_rate_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_gen_pkg.sv
// Shared types and default constants for the rate_gen data-rate clock generator.
package rate_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DIV_W_DEF       = 12;
  localparam int DEFAULT_DIV_DEF = 10;
  localparam int FRAC_W_DEF      = 4;

endpackage

// File: rtl/rate_frac_acc.sv
// Fractional accumulator for rate_gen. Adds the fractional numerator at each
// half-period boundary; a carry-out requests a one-cycle stretch of the next
// half-period. Only instantiated when RATE_GEN_FRAC_EN is defined.
module rate_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_boundary,
  input  logic              i_clear,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_stretch
);

  logic [FRAC_W-1:0] r_acc;
  logic              r_stretch;

  // Accumulate at each boundary; the carry stretches the half-period that follows.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc     <= '0;
      r_stretch <= 1'b0;
    end else if (i_clear) begin
      r_acc     <= '0;
      r_stretch <= 1'b0;
    end else if (i_boundary) begin
      {r_stretch, r_acc} <= {1'b0, r_acc} + {1'b0, i_frac};
    end
  end

  assign o_stretch = r_stretch;

endmodule

// File: rtl/rate_gen.sv
// Runtime-programmable data-rate clock generator: 50% duty square wave with
// rise (tick) and toggle (half_tick) strobes. The half-period divisor is
// loaded into a shadow register and applied only at half-period boundaries
// (or while idle) so the output never glitches.
// Optional fractional divisor: define RATE_GEN_FRAC_EN.
module rate_gen
  import rate_gen_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int FRAC_W      = FRAC_W_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_div_in,
  input  logic [FRAC_W-1:0] i_frac_in,
  input  logic              i_div_load,
  output logic              o_output_data_rate,
  output logic              o_tick,
  output logic              o_half_tick,
  output logic              o_load_pending,
  output logic              o_busy
);

`ifdef RATE_GEN_FRAC_EN
  // One extra counter bit so a stretched half-period of a full-scale divisor fits.
  localparam int CNT_W = DIV_W + 1;
`else
  localparam int CNT_W = DIV_W;
`endif

  state_e           r_state;
  logic [CNT_W-1:0] r_counter;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_shadow_div;
  logic             r_pending;
  logic             r_rate;
  logic             r_tick;
  logic             r_half_tick;
  logic             r_busy;

  logic             w_stretch;
  logic [CNT_W-1:0] w_term;
  logic             w_boundary;

  assign w_term     = CNT_W'(r_cur_div) + CNT_W'(w_stretch);
  assign w_boundary = (r_state == ST_RUN) && i_enable && (r_counter == w_term);

`ifdef RATE_GEN_FRAC_EN
  logic [FRAC_W-1:0] r_cur_frac;
  logic [FRAC_W-1:0] r_shadow_frac;
  logic              w_frac_clear;

  assign w_frac_clear = (r_state == ST_IDLE) || !i_enable;

  rate_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_boundary (w_boundary),
    .i_clear    (w_frac_clear),
    .i_frac     (r_cur_frac),
    .o_stretch  (w_stretch)
  );

  // Fractional shadow/current pair follows the same load/apply rules as the divisor.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cur_frac    <= '0;
      r_shadow_frac <= '0;
    end else begin
      if (i_div_load) r_shadow_frac <= i_frac_in;
      if (r_pending && (r_state == ST_IDLE || w_boundary)) r_cur_frac <= r_shadow_frac;
    end
  end
`else
  logic w_unused_frac;
  assign w_unused_frac = ^i_frac_in;
  assign w_stretch     = 1'b0;
`endif

  // Main sequencer: IDLE holds the output low, RUN counts half-periods and toggles.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_counter    <= '0;
      r_cur_div    <= DIV_W'(DEFAULT_DIV);
      r_shadow_div <= DIV_W'(DEFAULT_DIV);
      r_pending    <= 1'b0;
      r_rate       <= 1'b0;
      r_tick       <= 1'b0;
      r_half_tick  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_tick      <= 1'b0;
      r_half_tick <= 1'b0;
      if (i_div_load) r_shadow_div <= i_div_in;
      case (r_state)
        ST_IDLE: begin
          r_counter <= '0;
          r_rate    <= 1'b0;
          if (r_pending) r_cur_div <= r_shadow_div;
          // A load in this same cycle refills the shadow, so pending stays set.
          r_pending <= i_div_load;
          r_busy    <= i_enable;
          if (i_enable) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!i_enable) begin
            // Forced return to zero: no strobes on this fall.
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_counter <= '0;
            r_rate    <= 1'b0;
            r_pending <= r_pending | i_div_load;
          end else if (w_boundary) begin
            r_counter   <= '0;
            r_rate      <= ~r_rate;
            r_half_tick <= 1'b1;
            r_tick      <= ~r_rate;
            // Boundary applies the value that was already pending; a same-cycle
            // load only lands in the shadow and waits for the next boundary.
            if (r_pending) r_cur_div <= r_shadow_div;
            r_pending <= i_div_load;
          end else begin
            r_counter <= r_counter + 1'b1;
            r_pending <= r_pending | i_div_load;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_output_data_rate = r_rate;
  assign o_tick             = r_tick;
  assign o_half_tick        = r_half_tick;
  assign o_load_pending     = r_pending;
  assign o_busy             = r_busy;

endmodule

// File: tb/tb_rate_gen.sv
// Self-checking bench for rate_gen: a half-period-level reference model is
// compared against the DUT on every falling edge, and directed scenarios pin
// the measured half-period lengths to hand-computed values.
module tb_rate_gen;

  localparam int DIV_W  = 12;
  localparam int FRAC_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [DIV_W-1:0]  div_in = '0;
  logic [FRAC_W-1:0] frac_in = '0;
  logic              div_load = 1'b0;
  logic              o_rate, o_tick, o_half, o_pend, o_busy;

  int n_pass  = 0;
  int n_total = 0;

  rate_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(10), .FRAC_W(FRAC_W)) dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_enable           (enable),
    .i_div_in           (div_in),
    .i_frac_in          (frac_in),
    .i_div_load         (div_load),
    .o_output_data_rate (o_rate),
    .o_tick             (o_tick),
    .o_half_tick        (o_half),
    .o_load_pending     (o_pend),
    .o_busy             (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks how many edges remain until the next toggle and
  // which divisor/fraction the next half-period will use.
  bit m_run = 0, m_pend = 0, m_rate = 0, m_tick = 0, m_half = 0;
  int m_cur = 10, m_shadow = 10, m_cur_f = 0, m_shadow_f = 0;
  int m_acc = 0, m_remain = 0, m_sum = 0, m_carry = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_rate = 0; m_tick = 0; m_half = 0;
      m_cur = 10; m_shadow = 10; m_cur_f = 0; m_shadow_f = 0;
      m_acc = 0; m_remain = 0;
    end else begin
      m_tick = 0;
      m_half = 0;
      if (!m_run) begin
        if (m_pend) begin
          m_cur = m_shadow; m_cur_f = m_shadow_f; m_pend = 0;
        end
        m_acc = 0;
        if (enable) begin
          m_run = 1;
          m_remain = m_cur + 1;
        end
      end else if (!enable) begin
        m_run = 0; m_rate = 0; m_acc = 0;
      end else begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          m_carry = 0;
`ifdef RATE_GEN_FRAC_EN
          m_sum   = m_acc + m_cur_f;
          m_carry = m_sum / (1 << FRAC_W);
          m_acc   = m_sum % (1 << FRAC_W);
`endif
          m_rate = !m_rate;
          m_half = 1;
          m_tick = m_rate;
          if (m_pend) begin
            m_cur = m_shadow; m_cur_f = m_shadow_f; m_pend = 0;
          end
          m_remain = m_cur + 1 + m_carry;
        end
      end
      if (div_load) begin
        m_shadow = int'(div_in); m_shadow_f = int'(frac_in); m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("rate", int'(o_rate), int'(m_rate));
    check("tick", int'(o_tick), int'(m_tick));
    check("half_tick", int'(o_half), int'(m_half));
    check("load_pending", int'(o_pend), int'(m_pend));
    check("busy", int'(o_busy), int'(m_run));
  end

  // Cycles from the current falling edge to the next one showing half_tick.
  task automatic next_half(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_half && n < 300);
    if (n >= 300) check("half_tick_timeout", n, 0);
  endtask

  task automatic load(input int d, input int f);
    div_in   = DIV_W'(d);
    frac_in  = FRAC_W'(f);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n;
  int exp_frac[4];

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rate", int'(o_rate), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_pending", int'(o_pend), 0);

    // Defaults: half-period 11, first rise 11 cycles after RUN entry
    enable = 1'b1;
    @(negedge clk);
    check("run_entry_busy", int'(o_busy), 1);
    next_half(n);
    check("first_rise_len", n, 11);
    check("first_rise_tick", int'(o_tick), 1);
    next_half(n);
    check("default_high_len", n, 11);
    check("fall_no_tick", int'(o_tick), 0);
    next_half(n);
    check("default_low_len", n, 11);
    check("second_rise_tick", int'(o_tick), 1);

    // Load 4 mid-half-period: current half finishes at 11, then 5s
    repeat (5) @(negedge clk);
    load(4, 0);
    check("pending_after_load", int'(o_pend), 1);
    next_half(n);
    check("old_half_remaining", n, 5);
    check("pending_cleared", int'(o_pend), 0);
    next_half(n);
    check("div4_half_a", n, 5);
    next_half(n);
    check("div4_half_b", n, 5);

    // Load 0 coincident with a boundary, nothing previously pending
    repeat (4) @(negedge clk);
    div_in = '0; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    check("coincident_boundary", int'(o_half), 1);
    check("coincident_pending", int'(o_pend), 1);
    next_half(n);
    check("coincident_keeps_old", n, 5);
    next_half(n);
    check("div0_half_a", n, 1);
    next_half(n);
    check("div0_half_b", n, 1);

    // Back to 10, then two loads (7 then 3) in one half-period
    load(10, 0);
    next_half(n);
    check("div0_before_reload", n, 1);
    next_half(n);
    check("div10_half", n, 11);
    repeat (2) @(negedge clk);
    load(7, 0);
    load(3, 0);
    next_half(n);
    check("two_loads_old_remaining", n, 7);
    next_half(n);
    check("last_load_wins_a", n, 4);
    next_half(n);
    check("last_load_wins_b", n, 4);

    // Drop enable right after a rise
    for (int i = 0; i < 4 && !o_rate; i++) next_half(n);
    check("at_rise_before_drop", int'(o_rate), 1);
    enable = 1'b0;
    @(negedge clk);
    check("drop_rate", int'(o_rate), 0);
    check("drop_busy", int'(o_busy), 0);
    check("drop_no_tick", int'(o_tick), 0);
    enable = 1'b1;
    @(negedge clk);
    next_half(n);
    check("reenable_first_rise", n, 4);
    check("reenable_tick", int'(o_tick), 1);

    // Asynchronous reset mid-RUN
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_rate", int'(o_rate), 0);
    check("async_rst_busy", int'(o_busy), 0);
    check("async_rst_tick", int'(o_tick), 0);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Divisor 2 with fraction 8/16, loaded while idle
    load(2, 8);
    @(negedge clk);
    check("idle_apply_pending", int'(o_pend), 0);
    enable = 1'b1;
    @(negedge clk);
`ifdef RATE_GEN_FRAC_EN
    exp_frac = '{3, 3, 4, 3};
`else
    exp_frac = '{3, 3, 3, 3};
`endif
    for (int i = 0; i < 4; i++) begin
      next_half(n);
      check("frac_half", n, exp_frac[i]);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
